// File: rtl/ram_port_arbiter_if.sv
// Request/response bundle for the two requesters plus the shared RAM port.
interface ram_port_arbiter_if #(
  parameter int W = 32,
  parameter int L = 128
);
  localparam int AW = (L > 1) ? $clog2(L) : 1;
  localparam int SW = W / 8;

  // requester A
  logic          a_valid;
  logic          a_ready;
  logic          a_wr;
  logic [AW-1:0] a_addr;
  logic [W-1:0]  a_wdata;
  logic [SW-1:0] a_strb;
  logic          a_rsp_valid;
  logic [W-1:0]  a_rsp_rdata;
  logic          a_rsp_err;

  // requester B
  logic          b_valid;
  logic          b_ready;
  logic          b_wr;
  logic [AW-1:0] b_addr;
  logic [W-1:0]  b_wdata;
  logic [SW-1:0] b_strb;
  logic          b_rsp_valid;
  logic [W-1:0]  b_rsp_rdata;
  logic          b_rsp_err;

  // RAM port
  logic [AW-1:0] mem_addr;
  logic          mem_wr_ena;
  logic [W-1:0]  mem_wr_data;
  logic [W-1:0]  mem_rd_data;

  modport slave (
    input  a_valid, a_wr, a_addr, a_wdata, a_strb,
    output a_ready, a_rsp_valid, a_rsp_rdata, a_rsp_err,
    input  b_valid, b_wr, b_addr, b_wdata, b_strb,
    output b_ready, b_rsp_valid, b_rsp_rdata, b_rsp_err,
    output mem_addr, mem_wr_ena, mem_wr_data,
    input  mem_rd_data
  );

  modport master (
    output a_valid, a_wr, a_addr, a_wdata, a_strb,
    input  a_ready, a_rsp_valid, a_rsp_rdata, a_rsp_err,
    output b_valid, b_wr, b_addr, b_wdata, b_strb,
    input  b_ready, b_rsp_valid, b_rsp_rdata, b_rsp_err
  );

  modport ram (
    input  mem_addr, mem_wr_ena, mem_wr_data,
    output mem_rd_data
  );
endinterface

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one distributed-RAM port between requesters
// A and B; byte-strobed writes are a single-cycle read-modify-write.
module ram_port_arbiter #(
  parameter int W = 32,
  parameter int L = 128
) (
  input  logic                clk,
  input  logic                rst,
  ram_port_arbiter_if.slave   bus,
  output logic                busy
);
  localparam int AW = (L > 1) ? $clog2(L) : 1;
  localparam int SW = W / 8;
  localparam logic [AW:0] LIMIT = (AW+1)'(L);

  typedef enum logic { IDLE, ACCESS } state_t;
  typedef enum logic { REQ_A, REQ_B } req_t;

  state_t        state_q, state_d;
  req_t          last_grant_q, last_grant_d;
  req_t          id_q, id_d;
  logic          wr_q, wr_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [W-1:0]  wdata_q, wdata_d;
  logic [SW-1:0] strb_q, strb_d;
  logic          err_q, err_d;

  logic          a_rsp_valid_q, a_rsp_valid_d;
  logic [W-1:0]  a_rsp_rdata_q, a_rsp_rdata_d;
  logic          a_rsp_err_q, a_rsp_err_d;
  logic          b_rsp_valid_q, b_rsp_valid_d;
  logic [W-1:0]  b_rsp_rdata_q, b_rsp_rdata_d;
  logic          b_rsp_err_q, b_rsp_err_d;

  logic          grant_a, grant_b;
  logic [W-1:0]  mask;

  // Expand byte strobes of the latched request into a bit mask.
  always_comb begin
    mask = '0;
    for (int unsigned i = 0; i < SW; i++) begin
      mask[i*8 +: 8] = {8{strb_q[i]}};
    end
  end

  // Arbitration in IDLE, response capture in ACCESS.
  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    id_d          = id_q;
    wr_d          = wr_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    strb_d        = strb_q;
    err_d         = err_q;
    a_rsp_valid_d = 1'b0;
    a_rsp_rdata_d = a_rsp_rdata_q;
    a_rsp_err_d   = a_rsp_err_q;
    b_rsp_valid_d = 1'b0;
    b_rsp_rdata_d = b_rsp_rdata_q;
    b_rsp_err_d   = b_rsp_err_q;
    grant_a       = 1'b0;
    grant_b       = 1'b0;

    case (state_q)
      IDLE: begin
        grant_a = bus.a_valid && (!bus.b_valid || last_grant_q == REQ_B);
        grant_b = bus.b_valid && (!bus.a_valid || last_grant_q == REQ_A);
        if (grant_a) begin
          id_d         = REQ_A;
          wr_d         = bus.a_wr;
          addr_d       = bus.a_addr;
          wdata_d      = bus.a_wdata;
          strb_d       = bus.a_strb;
          err_d        = {1'b0, bus.a_addr} >= LIMIT;
          last_grant_d = REQ_A;
          state_d      = ACCESS;
        end else if (grant_b) begin
          id_d         = REQ_B;
          wr_d         = bus.b_wr;
          addr_d       = bus.b_addr;
          wdata_d      = bus.b_wdata;
          strb_d       = bus.b_strb;
          err_d        = {1'b0, bus.b_addr} >= LIMIT;
          last_grant_d = REQ_B;
          state_d      = ACCESS;
        end
      end
      ACCESS: begin
        if (id_q == REQ_A) begin
          a_rsp_valid_d = 1'b1;
          a_rsp_rdata_d = bus.mem_rd_data;
          a_rsp_err_d   = err_q;
        end else begin
          b_rsp_valid_d = 1'b1;
          b_rsp_rdata_d = bus.mem_rd_data;
          b_rsp_err_d   = err_q;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, latched request and response registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      last_grant_q  <= REQ_B;
      id_q          <= REQ_A;
      wr_q          <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      strb_q        <= '0;
      err_q         <= 1'b0;
      a_rsp_valid_q <= 1'b0;
      a_rsp_rdata_q <= '0;
      a_rsp_err_q   <= 1'b0;
      b_rsp_valid_q <= 1'b0;
      b_rsp_rdata_q <= '0;
      b_rsp_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      id_q          <= id_d;
      wr_q          <= wr_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      strb_q        <= strb_d;
      err_q         <= err_d;
      a_rsp_valid_q <= a_rsp_valid_d;
      a_rsp_rdata_q <= a_rsp_rdata_d;
      a_rsp_err_q   <= a_rsp_err_d;
      b_rsp_valid_q <= b_rsp_valid_d;
      b_rsp_rdata_q <= b_rsp_rdata_d;
      b_rsp_err_q   <= b_rsp_err_d;
    end
  end

  assign bus.a_ready     = grant_a;
  assign bus.b_ready     = grant_b;
  assign bus.a_rsp_valid = a_rsp_valid_q;
  assign bus.a_rsp_rdata = a_rsp_rdata_q;
  assign bus.a_rsp_err   = a_rsp_err_q;
  assign bus.b_rsp_valid = b_rsp_valid_q;
  assign bus.b_rsp_rdata = b_rsp_rdata_q;
  assign bus.b_rsp_err   = b_rsp_err_q;

  // Write is gated by state so reset drops it immediately.
  assign busy            = (state_q == ACCESS);
  assign bus.mem_addr    = addr_q;
  assign bus.mem_wr_ena  = (state_q == ACCESS) && wr_q && (strb_q != '0) && !err_q;
  assign bus.mem_wr_data = (bus.mem_rd_data & ~mask) | (wdata_q & mask);
endmodule

// File: tb/tb_ram_port_arbiter.sv
// Randomized self-checking bench for ram_port_arbiter against a
// transaction-level reference model (round-robin order, byte merge).
module tb_ram_port_arbiter;
  localparam int W     = 32;
  localparam int L     = 100;
  localparam int AW    = $clog2(L);
  localparam int SW    = W / 8;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;
  logic load = 1'b0;

  always #5 clk = ~clk;

  ram_port_arbiter_if #(.W(W), .L(L)) bus ();

  ram_port_arbiter #(.W(W), .L(L)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  // Distributed RAM stand-in: combinational read, write on posedge.
  logic [W-1:0] ram      [DEPTH];
  logic [W-1:0] init_val [DEPTH];
  logic [W-1:0] ref_mem  [DEPTH];

  assign bus.mem_rd_data = ram[bus.mem_addr];

  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= init_val[i];
    end else if (bus.mem_wr_ena) begin
      ram[bus.mem_addr] <= bus.mem_wr_data;
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] merge(input logic [W-1:0] old, input logic [W-1:0] nw,
                                         input logic [SW-1:0] st);
    logic [W-1:0] r;
    r = old;
    for (int i = 0; i < SW; i++) if (st[i]) r[i*8 +: 8] = nw[i*8 +: 8];
    return r;
  endfunction

  // Reference model state
  bit            m_busy;
  bit            m_last;       // 0 = A, 1 = B
  bit            m_id;
  bit            m_wr;
  bit            m_err;
  logic [AW-1:0] m_addr;
  logic [W-1:0]  m_wdata;
  logic [SW-1:0] m_strb;
  logic [W-1:0]  e_rdata [2];
  bit            e_err   [2];
  bit            auto_drop = 1'b1;

  task automatic model_reset();
    m_busy = 1'b0;
    m_last = 1'b1;
    e_rdata[0] = '0; e_rdata[1] = '0;
    e_err[0] = 1'b0; e_err[1] = 1'b0;
  endtask

  task automatic set_req(input bit who, input bit wr, input logic [AW-1:0] addr,
                         input logic [W-1:0] wd, input logic [SW-1:0] st);
    if (!who) begin
      bus.a_valid = 1'b1; bus.a_wr = wr; bus.a_addr = addr; bus.a_wdata = wd; bus.a_strb = st;
    end else begin
      bus.b_valid = 1'b1; bus.b_wr = wr; bus.b_addr = addr; bus.b_wdata = wd; bus.b_strb = st;
    end
  endtask

  // One clock cycle: check combinational outputs, advance, check responses.
  task automatic step();
    bit ga, gb, rsp_now, rsp_id, exp_we;
    #1;
    ga = !m_busy && bus.a_valid && (!bus.b_valid || m_last);
    gb = !m_busy && bus.b_valid && (!bus.a_valid || !m_last);
    exp_we = m_busy && m_wr && (m_strb != '0) && !m_err;
    check("a_ready", W'(bus.a_ready), W'(ga));
    check("b_ready", W'(bus.b_ready), W'(gb));
    check("busy", W'(busy), W'(m_busy));
    check("mem_wr_ena", W'(bus.mem_wr_ena), W'(exp_we));
    if (m_busy) check("mem_addr", W'(bus.mem_addr), W'(m_addr));
    if (exp_we) check("mem_wr_data", bus.mem_wr_data, merge(ref_mem[m_addr], m_wdata, m_strb));

    @(posedge clk);
    #1;
    rsp_now = m_busy;
    rsp_id  = m_id;
    if (rsp_now) begin
      if (!m_err) begin
        e_rdata[m_id] = ref_mem[m_addr];
        if (m_wr) ref_mem[m_addr] = merge(ref_mem[m_addr], m_wdata, m_strb);
      end
      e_err[m_id] = m_err;
    end
    check("a_rsp_valid", W'(bus.a_rsp_valid), W'(rsp_now && !rsp_id));
    check("b_rsp_valid", W'(bus.b_rsp_valid), W'(rsp_now && rsp_id));
    check("a_rsp_err", W'(bus.a_rsp_err), W'(e_err[0]));
    check("b_rsp_err", W'(bus.b_rsp_err), W'(e_err[1]));
    if (!e_err[0]) check("a_rsp_rdata", bus.a_rsp_rdata, e_rdata[0]);
    if (!e_err[1]) check("b_rsp_rdata", bus.b_rsp_rdata, e_rdata[1]);

    m_busy = ga || gb;
    if (ga) begin
      m_id = 1'b0; m_wr = bus.a_wr; m_addr = bus.a_addr; m_wdata = bus.a_wdata; m_strb = bus.a_strb;
    end else if (gb) begin
      m_id = 1'b1; m_wr = bus.b_wr; m_addr = bus.b_addr; m_wdata = bus.b_wdata; m_strb = bus.b_strb;
    end
    if (ga || gb) begin
      m_last = gb;
      m_err  = int'(m_addr) >= L;
    end
    if (auto_drop) begin
      if (ga) bus.a_valid = 1'b0;
      if (gb) bus.b_valid = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  bit            seq [$];
  logic [W-1:0]  wd;

  initial begin
    bus.a_valid = 1'b0; bus.a_wr = 1'b0; bus.a_addr = '0; bus.a_wdata = '0; bus.a_strb = '0;
    bus.b_valid = 1'b0; bus.b_wr = 1'b0; bus.b_addr = '0; bus.b_wdata = '0; bus.b_strb = '0;
    for (int i = 0; i < DEPTH; i++) init_val[i] = $urandom;
    init_val[5] = 32'hDEADBEEF;
    init_val[3] = 32'h11223344;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_val[i];

    load = 1'b1;
    do_reset();
    load = 1'b0;

    // reset state
    check("rst_a_rsp_valid", W'(bus.a_rsp_valid), '0);
    check("rst_b_rsp_valid", W'(bus.b_rsp_valid), '0);
    check("rst_a_rsp_rdata", bus.a_rsp_rdata, '0);
    check("rst_b_rsp_err", W'(bus.b_rsp_err), '0);
    check("rst_busy", W'(busy), '0);
    check("rst_mem_wr_ena", W'(bus.mem_wr_ena), '0);
    check("rst_mem_addr", W'(bus.mem_addr), '0);

    // A reads word 5
    set_req(1'b0, 1'b0, AW'(5), '0, '0);
    #1 check("t1_a_ready", W'(bus.a_ready), W'(1));
    step();
    step();
    check("t1_rdata", bus.a_rsp_rdata, 32'hDEADBEEF);
    check("t1_err", W'(bus.a_rsp_err), '0);
    step();

    // partial write to word 3, then read it back
    set_req(1'b0, 1'b1, AW'(3), 32'hAABBCCDD, 4'b0101);
    step();
    step();
    check("t2_old", bus.a_rsp_rdata, 32'h11223344);
    check("t2_ram", ram[3], 32'h11BB33DD);
    set_req(1'b0, 1'b0, AW'(3), '0, '0);
    step();
    step();
    check("t2_readback", bus.a_rsp_rdata, 32'h11BB33DD);

    // round-robin with both requesters held valid
    do_reset();
    auto_drop = 1'b0;
    set_req(1'b0, 1'b0, AW'(20), '0, '0);
    set_req(1'b1, 1'b0, AW'(21), '0, '0);
    for (int c = 0; c < 8; c++) begin
      #1;
      if (bus.a_ready) seq.push_back(1'b0);
      if (bus.b_ready) seq.push_back(1'b1);
      step();
    end
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
    auto_drop = 1'b1;
    check("rr_count", W'(seq.size()), W'(4));
    for (int i = 0; i < seq.size(); i++) check("rr_order", W'(seq[i]), W'(i % 2));
    step();

    // out-of-range write by B, in-range write at last word by A
    set_req(1'b1, 1'b1, AW'(100), 32'hCAFEF00D, 4'hF);
    step();
    step();
    check("t4_b_err", W'(bus.b_rsp_err), W'(1));
    check("t4_ram100", ram[100], init_val[100]);
    set_req(1'b0, 1'b1, AW'(99), 32'h0BADCAFE, 4'hF);
    step();
    step();
    check("t4_a_err", W'(bus.a_rsp_err), '0);
    check("t4_ram99", ram[99], 32'h0BADCAFE);

    // strobe-zero write behaves as a read
    set_req(1'b0, 1'b1, AW'(7), 32'h12345678, 4'h0);
    step();
    step();
    check("t5_ram7", ram[7], init_val[7]);
    check("t5_rdata", bus.a_rsp_rdata, init_val[7]);

    // reset asserted during the ACCESS cycle of a full write
    set_req(1'b0, 1'b1, AW'(10), 32'h55AA55AA, 4'hF);
    step();
    check("t6_busy_pre", W'(busy), W'(1));
    rst = 1'b1;
    model_reset();
    #1;
    check("t6_wr_ena", W'(bus.mem_wr_ena), '0);
    check("t6_busy", W'(busy), '0);
    @(posedge clk);
    #1;
    check("t6_no_rsp", W'(bus.a_rsp_valid), '0);
    check("t6_ram10", ram[10], ref_mem[10]);
    rst = 1'b0;
    set_req(1'b0, 1'b0, AW'(11), '0, '0);
    set_req(1'b1, 1'b0, AW'(12), '0, '0);
    #1;
    check("t6_a_first", W'(bus.a_ready), W'(1));
    check("t6_b_wait", W'(bus.b_ready), '0);
    for (int c = 0; c < 5; c++) step();

    // randomized traffic
    for (int c = 0; c < 400; c++) begin
      for (int r = 0; r < 2; r++) begin
        bit v;
        v = r ? bus.b_valid : bus.a_valid;
        if (!v && $urandom_range(0, 2) == 0) begin
          wd = $urandom;
          set_req(r[0], 1'($urandom_range(0, 1)), AW'($urandom_range(0, DEPTH - 1)), wd,
                  SW'($urandom_range(0, (1 << SW) - 1)));
        end else if (v && $urandom_range(0, 15) == 0) begin
          if (r == 0) bus.a_valid = 1'b0;
          else        bus.b_valid = 1'b0;
        end
      end
      step();
    end
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
    for (int c = 0; c < 3; c++) step();

    for (int i = 0; i < DEPTH; i++) check("ram_final", ram[i], ref_mem[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
Shares one port of the team's dual-port distributed RAM (word-wide, combinational read, write on posedge clk) between two requesters. A is the CPU data path; B is the debug/loader path. Arbitration is round-robin on a valid/ready handshake. Byte-strobed writes are performed as a single-cycle read-modify-write, which is possible because the RAM read is combinational. Out-of-range addresses are flagged as errors, and the RAM is not written.

Parameters:
W, 32, data word width; must be a multiple of 8.
L, 128, RAM depth in words; need not be a power of 2.

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
a_valid  in  1  requester A request valid
a_ready  out  1  A request accepted this cycle
a_wr  in  1  1 = write, 0 = read
a_addr  in  $clog2(L)  word address
a_wdata  in  W  write data
a_strb  in  W/8  byte write strobes
a_rsp_valid  out  1  one-cycle response pulse
a_rsp_rdata  out  W  word read (for writes: word value before the write)
a_rsp_err  out  1  address >= L; qualified by a_rsp_valid
b_valid, b_ready, b_wr, b_addr, b_wdata, b_strb, b_rsp_valid, b_rsp_rdata, b_rsp_err  same as A, for requester B
mem_addr  out  $clog2(L)  to RAM port addr
mem_wr_ena  out  1  to RAM port wr_ena
mem_wr_data  out  W  to RAM port wr_data
mem_rd_data  in  W  from RAM port rd_data (combinational)
busy  out  1  high when state is ACCESS

Behaviour:
- FSM has two states, IDLE and ACCESS. Latched request registers: id, wr, addr, wdata, strb, err. Register last_grant holds the most recently granted requester.
- Reset (async, any state, including mid-ACCESS) sets:
  - state = IDLE; last_grant = B, so A wins the first tie.
  - All latched registers = 0.
  - All rsp_valid, rsp_err, rsp_rdata = 0.
  - A write in progress is abandoned; mem_wr_ena drops with reset.
- IDLE arbitration:
  - Only one valid: that requester is granted.
  - Both valid: the requester not equal to last_grant is granted.
  - Neither valid: stay in IDLE.
- ready is combinational and is asserted only in IDLE, only for the granted requester. It never depends on that requester's own ready.
- On a grant: latch the request, set err = (addr >= L), update last_grant, go to ACCESS.
- Requesters must hold their request fields stable while valid && !ready. A requester may drop valid before it is granted.
- ACCESS (exactly one cycle):
  - mem_addr = latched addr.
  - Write enable: mem_wr_ena = wr && (strb != 0) && !err.
  - Merge: mem_wr_data = (mem_rd_data & ~M) | (wdata & M), where M expands each strobe bit to 8 bits.
  - Response registers are loaded at the ACCESS edge: rsp_rdata <= mem_rd_data (the old word), rsp_err <= err, rsp_valid of the latched id <= 1. Then go to IDLE.
- A write with strb == 0 behaves as a read: no RAM write, normal response.
- Out-of-range access: no RAM write. rsp_rdata = mem_rd_data, which is don't-care. rsp_err = 1.
- Outside ACCESS: mem_wr_ena = 0, mem_addr = latched addr, mem_wr_data = merge value (don't-care).
- Timing:
  - A handshake in cycle c puts ACCESS in c+1 and the response pulse in c+2.
  - A new grant may occur in c+2, giving a throughput of one transaction per 2 cycles.
  - rsp_valid is high for exactly one cycle. rsp_rdata and rsp_err hold until the next response to that requester.
- There is no response backpressure; requesters must accept responses.
- The other RAM port is outside this block. A same-cycle write to the same address through the other port has unspecified ordering and is not arbitrated here.

Test Plan:
- Reset then A read: RAM preloaded word[5] = 32'hDEADBEEF; A reads addr 5 -> a_ready in cycle 0, busy in cycle 1, a_rsp_valid in cycle 2 with rdata DEADBEEF, err 0; b_rsp_valid stays 0 throughout.
- Partial write: word[3] = 32'h11223344; A writes wdata 32'hAABBCCDD, strb 4'b0101 -> RAM word[3] = 32'h11BB33DD; rsp_rdata = 32'h11223344; subsequent read returns 32'h11BB33DD.
- Round-robin: A and B both held valid for 8 cycles with reads -> grants alternate A, B, A, B starting with A; each ready pulse is separated by 2 cycles; no grant goes to the same requester twice while the other waits.
- Boundary: with L = 100, B writes addr 100, strb 4'hF -> no mem_wr_ena pulse, b_rsp_err = 1; a write to addr 99 succeeds with err = 0.
- Strobe zero: A write with strb 0 to addr 7 -> RAM word[7] is unchanged and the response returns its value.
- Reset mid-operation: assert rst during the ACCESS cycle of a full write -> mem_wr_ena = 0 immediately, no response pulse, state IDLE; after reset release, a simultaneous A/B request grants A first.
